seg7_reader: RTL and testbench

SEG7_READER -- requirements
Module: seg7_reader

---
 rtl/seg7_pkg.sv | 41 ++++
 rtl/seg7_pat_decode.sv | 42 ++++
 rtl/seg7_reader.sv | 111 +++++++++++
 tb/tb_seg7_reader.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment word reader.
// Optional build macro: SEG7_READER_BLANK_EN (all-off pattern decodes as 0).
package seg7_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_COLLECT = 2'b01,
    ST_HOLD    = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    ERR_BAD_PAT = 2'b00,
    ERR_BAD_SEL = 2'b01,
    ERR_TIMEOUT = 2'b10,
    ERR_OVERRUN = 2'b11
  } err_t;

  // Active-low segment patterns, bit6=g .. bit0=a
  localparam logic [6:0] PAT_0     = 7'b1000000;
  localparam logic [6:0] PAT_1     = 7'b1111001;
  localparam logic [6:0] PAT_2     = 7'b0100100;
  localparam logic [6:0] PAT_3     = 7'b0110000;
  localparam logic [6:0] PAT_4     = 7'b0011001;
  localparam logic [6:0] PAT_5     = 7'b0010010;
  localparam logic [6:0] PAT_6     = 7'b0000010;
  localparam logic [6:0] PAT_7     = 7'b1111000;
  localparam logic [6:0] PAT_8     = 7'b0000000;
  localparam logic [6:0] PAT_9     = 7'b0010000;
  localparam logic [6:0] PAT_A     = 7'b0001000;
  localparam logic [6:0] PAT_B     = 7'b0000011;
  localparam logic [6:0] PAT_C     = 7'b1000110;
  localparam logic [6:0] PAT_D     = 7'b0100001;
  localparam logic [6:0] PAT_E     = 7'b0000110;
  localparam logic [6:0] PAT_F     = 7'b0001110;
  localparam logic [6:0] PAT_BLANK = 7'b1111111;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/seg7_pat_decode.sv
// Combinational seven-segment pattern to hex nibble decoder.
// Optional build macro: SEG7_READER_BLANK_EN (all-off pattern decodes as 0).
module seg7_pat_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       valid
);

  // Map each legal pattern to its nibble; anything else is flagged invalid
  always_comb begin
    nibble = 4'h0;
    valid  = 1'b1;
    case (seg)
      PAT_0:     nibble = 4'h0;
      PAT_1:     nibble = 4'h1;
      PAT_2:     nibble = 4'h2;
      PAT_3:     nibble = 4'h3;
      PAT_4:     nibble = 4'h4;
      PAT_5:     nibble = 4'h5;
      PAT_6:     nibble = 4'h6;
      PAT_7:     nibble = 4'h7;
      PAT_8:     nibble = 4'h8;
      PAT_9:     nibble = 4'h9;
      PAT_A:     nibble = 4'hA;
      PAT_B:     nibble = 4'hB;
      PAT_C:     nibble = 4'hC;
      PAT_D:     nibble = 4'hD;
      PAT_E:     nibble = 4'hE;
      PAT_F:     nibble = 4'hF;
`ifdef SEG7_READER_BLANK_EN
      PAT_BLANK: nibble = 4'h0;
`endif
      default: begin
        nibble = 4'h0;
        valid  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seg7_reader.sv
// Reassembles a 16-bit word from strobed seven-segment digit samples and
// presents it with a valid/ready handshake; reports malformed strobes,
// inter-digit timeouts and overruns as one-cycle error pulses.
// Optional build macro: SEG7_READER_BLANK_EN (all-off pattern decodes as 0).
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg_i,
  input  logic [3:0]  dig_sel_i,
  input  logic        seg_vld_i,
  input  logic        ready_i,
  output logic [15:0] hex_o,
  output logic        hex_vld_o,
  output logic        err_o,
  output logic [1:0]  err_code_o
);

  state_t      state;
  logic [3:0]  got;
  logic [15:0] cnt;

  logic [3:0]  dec_nib;
  logic        dec_vld;
  logic        sel_ok;
  logic        take;
  logic [3:0]  got_wr;
  logic [15:0] hex_wr;

  seg7_pat_decode u_dec (
    .seg    (seg_i),
    .nibble (dec_nib),
    .valid  (dec_vld)
  );

  // Strobe qualification and the word/mask as they would look after capture.
  // A strobe taken in HOLD (ready_i=1) starts a fresh word, so the mask base is empty.
  always_comb begin
    sel_ok = is_onehot4(dig_sel_i);
    take   = seg_vld_i && ((state != ST_HOLD) || ready_i);
    got_wr = ((state == ST_HOLD) ? 4'b0000 : got) | dig_sel_i;
    hex_wr = hex_o;
    for (int unsigned i = 0; i < 4; i++) begin
      if (dig_sel_i[i]) hex_wr[i*4 +: 4] = dec_nib;
    end
  end

  // Main control FSM with registered outputs; later assignments override the
  // handshake release so a strobe on the release cycle is handled in one step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      got        <= '0;
      cnt        <= '0;
      hex_o      <= '0;
      hex_vld_o  <= 1'b0;
      err_o      <= 1'b0;
      err_code_o <= ERR_BAD_PAT;
    end else begin
      err_o <= 1'b0;
      if (state != ST_COLLECT) cnt <= '0;

      if ((state == ST_HOLD) && ready_i) begin
        hex_vld_o <= 1'b0;
        got       <= '0;
        state     <= ST_IDLE;
      end

      if (take) begin
        cnt <= '0;
        if (!sel_ok) begin
          err_o      <= 1'b1;
          err_code_o <= ERR_BAD_SEL;
          got        <= '0;
          state      <= ST_IDLE;
        end else if (!dec_vld) begin
          err_o      <= 1'b1;
          err_code_o <= ERR_BAD_PAT;
          got        <= '0;
          state      <= ST_IDLE;
        end else begin
          hex_o <= hex_wr;
          got   <= got_wr;
          if (got_wr == 4'b1111) begin
            state     <= ST_HOLD;
            hex_vld_o <= 1'b1;
          end else begin
            state <= ST_COLLECT;
          end
        end
      end else if ((state == ST_HOLD) && seg_vld_i) begin
        err_o      <= 1'b1;
        err_code_o <= ERR_OVERRUN;
      end else if (state == ST_COLLECT) begin
        if (cnt == 16'(TIMEOUT - 1)) begin
          err_o      <= 1'b1;
          err_code_o <= ERR_TIMEOUT;
          got        <= '0;
          cnt        <= '0;
          state      <= ST_IDLE;
        end else begin
          cnt <= cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_reader.sv
// Directed self-checking bench for seg7_reader (TIMEOUT overridden to 8).
// Optional build macro: SEG7_READER_BLANK_EN selects the blank-digit scenario.
module tb_seg7_reader;

  logic        clk;
  logic        rst;
  logic [6:0]  seg_i;
  logic [3:0]  dig_sel_i;
  logic        seg_vld_i;
  logic        ready_i;
  logic [15:0] hex_o;
  logic        hex_vld_o;
  logic        err_o;
  logic [1:0]  err_code_o;

  int n_checks = 0;
  int n_fail   = 0;

  seg7_reader #(.TIMEOUT(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .seg_i      (seg_i),
    .dig_sel_i  (dig_sel_i),
    .seg_vld_i  (seg_vld_i),
    .ready_i    (ready_i),
    .hex_o      (hex_o),
    .hex_vld_o  (hex_vld_o),
    .err_o      (err_o),
    .err_code_o (err_code_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] pat_of(input int n);
    case (n)
      0:  return 7'b1000000;
      1:  return 7'b1111001;
      2:  return 7'b0100100;
      3:  return 7'b0110000;
      4:  return 7'b0011001;
      5:  return 7'b0010010;
      6:  return 7'b0000010;
      7:  return 7'b1111000;
      8:  return 7'b0000000;
      9:  return 7'b0010000;
      10: return 7'b0001000;
      11: return 7'b0000011;
      12: return 7'b1000110;
      13: return 7'b0100001;
      14: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  // Drive one cycle of inputs from a falling edge; returns at the next falling edge
  task automatic step(input logic v, input logic [3:0] s, input logic [6:0] p);
    seg_vld_i = v;
    dig_sel_i = s;
    seg_i     = p;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 4'b0000, 7'b1111111);
  endtask

  task automatic strobe(input int d, input int n);
    step(1'b1, 4'b0001 << d, pat_of(n));
  endtask

  int errs;

  initial begin
    rst = 1'b1;
    seg_vld_i = 1'b0;
    dig_sel_i = 4'b0000;
    seg_i = 7'b1111111;
    ready_i = 1'b0;
    @(negedge clk);
    check_eq("rst_hex", 32'(hex_o), 32'h0);
    check_eq("rst_vld", 32'(hex_vld_o), 32'h0);
    check_eq("rst_err", 32'(err_o), 32'h0);
    check_eq("rst_code", 32'(err_code_o), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // 1234 with ready held high; first strobe on the first edge after reset
    ready_i = 1'b1;
    strobe(0, 4);
    strobe(1, 3);
    strobe(2, 2);
    check_eq("w1234_vld_early", 32'(hex_vld_o), 32'h0);
    strobe(3, 1);
    check_eq("w1234_vld", 32'(hex_vld_o), 32'h1);
    check_eq("w1234_hex", 32'(hex_o), 32'h1234);
    idle();
    check_eq("w1234_release", 32'(hex_vld_o), 32'h0);
    check_eq("w1234_noerr", 32'(err_o), 32'h0);
    ready_i = 1'b0;

    // BEEF held against backpressure with one overrun strobe
    strobe(0, 15);
    strobe(1, 14);
    strobe(2, 14);
    strobe(3, 11);
    check_eq("beef_vld", 32'(hex_vld_o), 32'h1);
    check_eq("beef_hex", 32'(hex_o), 32'hBEEF);
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) strobe(0, 0);
      else idle();
      if (err_o) errs++;
      if (i == 4) check_eq("ovr_code", 32'(err_code_o), 32'h3);
      check_eq("beef_hold_vld", 32'(hex_vld_o), 32'h1);
      check_eq("beef_hold_hex", 32'(hex_o), 32'hBEEF);
    end
    check_eq("ovr_once", 32'(errs), 32'h1);
    ready_i = 1'b1;
    idle();
    check_eq("beef_release", 32'(hex_vld_o), 32'h0);
    ready_i = 1'b0;

    // Non-one-hot select clears the partial word
    strobe(0, 5);
    step(1'b1, 4'b0011, pat_of(7));
    check_eq("badsel_err", 32'(err_o), 32'h1);
    check_eq("badsel_code", 32'(err_code_o), 32'h1);
    strobe(1, 6);
    check_eq("badsel_pulse", 32'(err_o), 32'h0);
    strobe(2, 7);
    strobe(3, 8);
    check_eq("badsel_gotclr", 32'(hex_vld_o), 32'h0);
    check_eq("badsel_stale", 32'(hex_o), 32'h8765);
    strobe(0, 9);
    check_eq("after_sel_vld", 32'(hex_vld_o), 32'h1);
    check_eq("after_sel_hex", 32'(hex_o), 32'h8769);
    ready_i = 1'b1;
    idle();
    ready_i = 1'b0;

    // BAD_SEL outranks BAD_PAT; empty select is also a bad select
    step(1'b1, 4'b0101, 7'b1111111);
    check_eq("prio_code", 32'(err_code_o), 32'h1);
    step(1'b1, 4'b0000, pat_of(0));
    check_eq("zero_sel_code", 32'(err_code_o), 32'h1);
    step(1'b1, 4'b0001, 7'b0101010);
    check_eq("badpat_err", 32'(err_o), 32'h1);
    check_eq("badpat_code", 32'(err_code_o), 32'h0);
    check_eq("badpat_hex", 32'(hex_o), 32'h8769);
    idle();
    check_eq("badpat_pulse", 32'(err_o), 32'h0);

    // Inter-digit timeout after exactly 8 idle cycles
    strobe(0, 1);
    strobe(1, 2);
    for (int i = 0; i < 8; i++) begin
      idle();
      check_eq("tmo_err", 32'(err_o), (i == 7) ? 32'h1 : 32'h0);
      if (i == 7) check_eq("tmo_code", 32'(err_code_o), 32'h2);
    end
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      idle();
      if (err_o) errs++;
    end
    check_eq("tmo_once", 32'(errs), 32'h0);
    strobe(2, 3);
    strobe(3, 4);
    check_eq("tmo_gotclr", 32'(hex_vld_o), 32'h0);
    step(1'b1, 4'b0011, pat_of(0));
    check_eq("clr_code", 32'(err_code_o), 32'h1);

    // All-off pattern on digit 2
    strobe(0, 13);
    strobe(1, 12);
    step(1'b1, 4'b0100, 7'b1111111);
`ifdef SEG7_READER_BLANK_EN
    check_eq("blank_noerr", 32'(err_o), 32'h0);
    strobe(3, 10);
    check_eq("blank_vld", 32'(hex_vld_o), 32'h1);
    check_eq("blank_hex", 32'(hex_o), 32'hA0CD);
`else
    check_eq("blank_err", 32'(err_o), 32'h1);
    check_eq("blank_code", 32'(err_code_o), 32'h0);
    strobe(3, 10);
    check_eq("blank_vld", 32'(hex_vld_o), 32'h0);
`endif
    ready_i = 1'b1;
    idle();
    ready_i = 1'b0;

    // Asynchronous reset mid-word, between clock edges
    strobe(0, 5);
    strobe(1, 6);
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_hex", 32'(hex_o), 32'h0);
    check_eq("arst_vld", 32'(hex_vld_o), 32'h0);
    check_eq("arst_err", 32'(err_o), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    ready_i = 1'b1;
    strobe(0, 15);
    strobe(1, 0);
    strobe(2, 15);
    check_eq("w0f0f_vld_early", 32'(hex_vld_o), 32'h0);
    strobe(3, 0);
    check_eq("w0f0f_vld", 32'(hex_vld_o), 32'h1);
    check_eq("w0f0f_hex", 32'(hex_o), 32'h0F0F);
    idle();
    check_eq("w0f0f_release", 32'(hex_vld_o), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
